// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: shared widths, constants and the fetch-queue entry type
package instruction_fetch_unit_pkg;
  localparam int INSTR_W = 32;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush; output reads as zero while empty
module fetch_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end
  assign dout = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner, imem read, fetch queue toward decode, redirect flush.
// Optional FETCH_STATS_EN adds stat_fetched/stat_flushes counters.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic [XLEN-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [XLEN-1:0]    if_pc,
  output logic               misalign_err
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]        stat_fetched,
  output logic [15:0]        stat_flushes
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [XLEN-1:0] pc;
  logic [CW-1:0] count;
  logic deq, enq;
  fetch_entry_t din, head;
  assign imem_pc = pc;
  assign if_valid = count != '0;
  assign deq = if_valid && if_ready;
  assign enq = fetch_en && !redirect_valid && (count < CW'(FIFO_DEPTH) || deq);
  assign din = '{pc: pc, instr: imem_instr};
  assign if_instr = head.instr;
  assign if_pc = head.pc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      misalign_err <= 1'b0;
    end else if (redirect_valid) begin
      pc <= align_pc(redirect_pc);
      if (|redirect_pc[1:0]) misalign_err <= 1'b1;
    end else if (enq) begin
      pc <= pc + PC_STEP;
    end
  end
  fetch_fifo #(.W($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (enq),
    .pop   (deq),
    .flush (redirect_valid),
    .din   (din),
    .dout  (head),
    .count (count)
  );
`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetched <= '0;
      stat_flushes <= '0;
    end else begin
      stat_fetched <= stat_fetched + 32'(enq);
      stat_flushes <= stat_flushes + 16'(redirect_valid);
    end
  end
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: queue-based reference model plus directed literal checks
module tb_instruction_fetch_unit;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst_n, fetch_en, redirect_valid, if_ready, if_valid, misalign_err;
  logic [31:0] imem_pc, imem_instr, redirect_pc, if_instr, if_pc;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A00_0000;
  endfunction
  assign imem_instr = word_at(imem_pc);
  instruction_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .misalign_err   (misalign_err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask
  logic [63:0] mq[$];
  logic [31:0] mpc = 32'h0;
  logic mmis = 1'b0;
  bit md, me;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mpc = 32'h0;
      mmis = 1'b0;
    end else begin
      md = mq.size() > 0 && if_ready;
      me = fetch_en && (mq.size() < DEPTH || md);
      if (redirect_valid) begin
        mq.delete();
        mpc = redirect_pc & ~32'd3;
        if (redirect_pc[1:0] != 2'b00) mmis = 1'b1;
      end else begin
        if (md) void'(mq.pop_front());
        if (me) begin
          mq.push_back({mpc, word_at(mpc)});
          mpc += 32'd4;
        end
      end
    end
  end
  always @(negedge clk) begin
    chk("m_valid", 32'(if_valid), 32'(mq.size() != 0));
    chk("m_imem_pc", imem_pc, mpc);
    chk("m_misalign", 32'(misalign_err), 32'(mmis));
    if (mq.size() != 0) begin
      chk("m_if_pc", if_pc, mq[0][63:32]);
      chk("m_if_instr", if_instr, mq[0][31:0]);
    end
  end
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    rst_n = 1'b0; fetch_en = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    cyc(2);
    chk("rst_valid", 32'(if_valid), 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_if_instr", if_instr, 0);
    chk("rst_imem_pc", imem_pc, 0);
    chk("rst_misalign", 32'(misalign_err), 0);
    rst_n = 1'b1;
    cyc();
    chk("lat_valid", 32'(if_valid), 1);
    chk("seq_pc0", if_pc, 32'h0);
    chk("seq_w0", if_instr, 32'hA5FF_0000);
    cyc();
    chk("seq_pc4", if_pc, 32'h4);
    chk("seq_w1", if_instr, 32'hA5FB_0004);
    cyc();
    chk("seq_pc8", if_pc, 32'h8);
    chk("seq_w2", if_instr, 32'hA5F7_0008);
    cyc();
    chk("seq_pcc", if_pc, 32'hC);
    chk("seq_w3", if_instr, 32'hA5F3_000C);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; if_ready = 1'b0;
    cyc(5);
    chk("stall_pc", if_pc, 32'h0);
    chk("stall_instr", if_instr, 32'hA5FF_0000);
    chk("stall_imem", imem_pc, 32'h8);
    if_ready = 1'b1;
    cyc();
    chk("drain_pc4", if_pc, 32'h4);
    chk("drain_imem", imem_pc, 32'hC);
    if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h10;
    cyc();
    chk("redir_flush", 32'(if_valid), 0);
    chk("redir_imem", imem_pc, 32'h10);
    redirect_valid = 1'b0; if_ready = 1'b1;
    cyc();
    chk("redir_if_pc", if_pc, 32'h10);
    chk("redir_imem2", imem_pc, 32'h14);
    redirect_valid = 1'b1; redirect_pc = 32'hE;
    cyc();
    chk("mis_set", 32'(misalign_err), 1);
    chk("mis_imem", imem_pc, 32'hC);
    redirect_valid = 1'b0;
    cyc();
    chk("mis_if_pc", if_pc, 32'hC);
    fetch_en = 1'b0;
    cyc(3);
    chk("hold_imem", imem_pc, 32'h10);
    chk("hold_empty", 32'(if_valid), 0);
    chk("mis_sticky", 32'(misalign_err), 1);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    chk("wrap_imem", imem_pc, 32'hFFFF_FFFC);
    redirect_valid = 1'b0; fetch_en = 1'b1;
    cyc();
    chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_imem0", imem_pc, 32'h0);
    cyc();
    chk("wrap_if_pc0", if_pc, 32'h0);
    for (int i = 0; i < 60; i++) begin
      if_ready = (i % 3) != 0;
      fetch_en = (i % 5) != 4;
      redirect_valid = (i % 13) == 6;
      redirect_pc = 32'(i * 36 + i % 3);
      cyc();
    end
    redirect_valid = 1'b0; fetch_en = 1'b1; if_ready = 1'b0;
    cyc(3);
    chk("full_valid", 32'(if_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(if_valid), 0);
    chk("arst_imem", imem_pc, 32'h0);
    chk("arst_mis", 32'(misalign_err), 0);
    chk("arst_if_pc", if_pc, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; if_ready = 1'b1;
    cyc(4);
    chk("post_rst_pc", if_pc, 32'hC);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
